seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial sequence detector, successor to the fixed-pattern Mealy detector. It watches a qualified 1-bit input stream for a runtime-loadable pattern of 1 to PAT_WIDTH bits. Overlapping or non-overlapping matching is selectable, and it produces both a Mealy (same-cycle) and a registered Moore-style match flag plus a saturating match counter. It sits at the serial front end as a drop-in generalisation of the single-pattern detector.

## Interface
- PAT_WIDTH, 4: maximum pattern length in bits (≥2).
- CNT_WIDTH, 8: match counter width (≥1).
- PAT_RESET, 4'b1011: pattern value after reset (PAT_WIDTH bits).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap, and clears detection state.
- cfg_pattern  in  PAT_WIDTH  pattern; bit cfg_len-1 is the first bit received, bit 0 is the last.
- cfg_len  in  $clog2(PAT_WIDTH+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  Mealy match: high in the cycle the completing bit is presented.
- z_q  out  1  z registered; high for one cycle after the matching edge.
- match_cnt  out  CNT_WIDTH  saturating count of matches.

## Operation
- Config registers: pat, len, ovl.
  - Reset values: PAT_RESET, PAT_WIDTH, 1.
  - Updated only on cfg_load.
  - A cfg_len of 0 or >PAT_WIDTH is stored as PAT_WIDTH.
- Detection state:
  - hist: PAT_WIDTH-bit shift register, new bit enters at LSB.
  - fill: valid-bit count, 0..PAT_WIDTH, saturates at PAT_WIDTH.
- Candidate window w = {hist[PAT_WIDTH-2:0], x}.
- Match condition: x_valid & (fill+1 ≥ len) & (w[len-1:0] == pat[len-1:0]).
  - z equals this condition combinationally.
  - z is forced 0 while rst is high.
- On a rising edge with x_valid=1:
  - hist ← w.
  - If there is a match and ovl=0: fill ← 0.
  - Otherwise: fill ← min(fill+1, PAT_WIDTH).
- x_valid=0: hist and fill hold; z=0.
- z_q ← z every edge.
- match_cnt:
  - Increments on each match.
  - Holds at 2^CNT_WIDTH-1; no wrap.
- Precedence and simultaneous events:
  - cfg_load high: hist and fill are cleared to 0, z is forced 0 that cycle, and any concurrent x_valid bit is discarded. match_cnt is untouched.
  - cnt_clr with a concurrent match: match_cnt ← 0 (clear wins).
  - cfg_load with cnt_clr: both actions occur.
- Reset, asynchronous, including mid-sequence: hist=0, fill=0, z_q=0, match_cnt=0, config = reset values. Partial matches are lost.

## Timing
- Mealy latency 0: z is valid combinationally in the cycle the last pattern bit is on x with x_valid.
- z_q and match_cnt update on the edge that accepts the completing bit. They are visible one cycle after z.
- A new config is effective for the bit presented in the cycle after the cfg_load cycle.
- Throughput: one bit per cycle. Back-to-back matches are possible every cycle in overlap mode (e.g. pattern 11, stream of 1s).
- No handshake back-pressure; the block is always ready.

## Test plan
- Overlap, defaults (1011, len 4, ovl 1), stream 1,0,1,1,0,1,1 with x_valid held high -> z high on bits 4 and 7 only; z_q high one cycle after each; match_cnt=2.
- Non-overlap: cfg_load with pattern 1011, len 4, ovl 0; same stream -> z only on bit 4; match_cnt=1.
- Short pattern: cfg_load pattern 3'b101, len 3.
  - ovl=1, stream 1,0,1,0,1 -> matches on bits 3 and 5.
  - ovl=0, same stream -> match on bit 3 only.
- Valid gaps: stream 1,0,1,1 with x_valid low for 3 cycles between bits 2 and 3 -> single match on bit 4; z=0 in all gap cycles.
- Saturation and clear: CNT_WIDTH=2, pattern 11, len 2, ovl 1, six 1s -> match_cnt 1,2,3,3,3 (five matches). Then cnt_clr together with a match -> match_cnt=0.
- Reset mid-sequence: after bits 1,0,1 of 1011, pulse rst asynchronously off-edge -> z_q and match_cnt 0 immediately. A following single 1 gives no match; a full 1,0,1,1 then matches on its 4th bit.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a runtime-loadable pattern
// of 1..PAT_WIDTH bits. It supports overlapping and non-overlapping matching,
// a Mealy match flag, a registered match flag and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned          PAT_WIDTH = 4,
    parameter int unsigned          CNT_WIDTH = 8,
    parameter logic [PAT_WIDTH-1:0] PAT_RESET = 4'b1011
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           x,
    input  logic                           x_valid,
    input  logic                           cfg_load,
    input  logic [PAT_WIDTH-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_WIDTH+1)-1:0] cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           z,
    output logic                           z_q,
    output logic [CNT_WIDTH-1:0]           match_cnt
);

    localparam int unsigned   LW      = $clog2(PAT_WIDTH + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(PAT_WIDTH);

    logic [PAT_WIDTH-1:0] pat_q;
    logic [LW-1:0]        len_q;
    logic                 ovl_q;
    logic [LW-1:0]        len_clamped;

    logic [PAT_WIDTH-1:0] hist_q, hist_d;
    logic [LW-1:0]        fill_q, fill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [PAT_WIDTH-1:0] window;
    logic [PAT_WIDTH-1:0] mask;
    logic                 fill_ok;

    // Lengths of 0 or beyond the register width fall back to the full width.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // Match condition on the candidate window; suppressed by reset and cfg_load.
    always_comb begin
        window = {hist_q[PAT_WIDTH-2:0], x};
        mask   = '0;
        for (int unsigned i = 0; i < PAT_WIDTH; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        fill_ok = ((LW+1)'(fill_q) + (LW+1)'(1)) >= (LW+1)'(len_q);
        z = x_valid & ~cfg_load & ~rst & fill_ok &
            ((window & mask) == (pat_q & mask));
    end

    // Next-state for the history, fill level and saturating counter.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = window;
            if (z && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (z && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Configuration registers, loaded only on the cfg_load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= PAT_RESET;
            len_q <= LEN_MAX;
            ovl_q <= 1'b1;
        end else if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= len_clamped;
            ovl_q <= cfg_overlap;
        end
    end

    // Detection state, registered match flag and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z;
        end
    end

    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: the expected z_q/match_cnt are queued as each
// bit is driven and compared after the edge that accepts it.
module tb_seq_detect_param;

    localparam int unsigned PW   = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          x = 1'b0;
    logic          x_valid = 1'b0;
    logic          cfg_load = 1'b0;
    logic [PW-1:0] cfg_pattern = '0;
    logic [2:0]    cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          z;
    logic          z_q;
    logic [CW-1:0] match_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_cnt  = 0;
    logic [CW:0] sb_q[$];

    seq_detect_param #(
        .PAT_WIDTH(PW),
        .CNT_WIDTH(CW),
        .PAT_RESET(4'b1011)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x(x),
        .x_valid(x_valid),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr),
        .z(z),
        .z_q(z_q),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, check Mealy z, queue expectation, then check registered outputs.
    task automatic step(input logic v, input logic b, input logic ez, input logic clr);
        logic [CW:0] e;
        @(negedge clk);
        cfg_load = 1'b0;
        cnt_clr  = clr;
        x_valid  = v;
        x        = b;
        #1;
        n_checks++;
        if (z !== ez) begin
            n_fail++;
            $display("FAIL z: got %b expected %b (v=%b x=%b) t=%0t", z, ez, v, b, $time);
        end
        if (clr) exp_cnt = 0;
        else if (ez && exp_cnt != CMAX) exp_cnt++;
        sb_q.push_back({ez, CW'(exp_cnt)});
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (z_q !== e[CW] || match_cnt !== e[CW-1:0]) begin
                n_fail++;
                $display("FAIL zq_cnt: got z_q=%b cnt=%0d expected z_q=%b cnt=%0d t=%0t",
                         z_q, match_cnt, e[CW], e[CW-1:0], $time);
            end
        end
    endtask

    // Load a configuration; a valid 1 is presented concurrently and must be discarded.
    task automatic do_cfg(input logic [PW-1:0] p, input logic [2:0] l, input logic o,
                          input logic clr);
        logic [CW:0] e;
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cnt_clr     = clr;
        x_valid     = 1'b1;
        x           = 1'b1;
        #1;
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_z: got %b expected 0 during cfg_load", z);
        end
        if (clr) exp_cnt = 0;
        sb_q.push_back({1'b0, CW'(exp_cnt)});
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        x_valid  = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (z_q !== e[CW] || match_cnt !== e[CW-1:0]) begin
            n_fail++;
            $display("FAIL cfg_cnt: got z_q=%b cnt=%0d expected z_q=%b cnt=%0d",
                     z_q, match_cnt, e[CW], e[CW-1:0]);
        end
    endtask

    task automatic run_stream(input logic [15:0] bits, input logic [15:0] ez, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], ez[i], 1'b0);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        x_valid = 1'b1;
        x       = 1'b1;
        #11;
        n_checks++;
        if (z_q !== 1'b0 || match_cnt !== '0 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got z=%b z_q=%b cnt=%0d expected 0 0 0", z, z_q, match_cnt);
        end
        @(negedge clk);
        x_valid = 1'b0;
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_overlap;
        run_stream(16'b1011011, 16'b0001001, 7);
    endtask

    task automatic test_nonoverlap;
        do_cfg(4'b1011, 3'd4, 1'b0, 1'b1);
        run_stream(16'b1011011, 16'b0001000, 7);
    endtask

    task automatic test_short;
        do_cfg(4'b0101, 3'd3, 1'b1, 1'b1);
        run_stream(16'b10101, 16'b00101, 5);
        do_cfg(4'b0101, 3'd3, 1'b0, 1'b1);
        run_stream(16'b10101, 16'b00100, 5);
    endtask

    task automatic test_valid_gaps;
        do_cfg(4'b1011, 3'd4, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_len_bounds;
        do_cfg(4'b1011, 3'd0, 1'b1, 1'b1);
        run_stream(16'b1011, 16'b0001, 4);
        do_cfg(4'b1011, 3'd7, 1'b1, 1'b1);
        run_stream(16'b1011, 16'b0001, 4);
        do_cfg(4'b0001, 3'd1, 1'b1, 1'b1);
        run_stream(16'b101, 16'b101, 3);
    endtask

    task automatic test_back_to_back;
        do_cfg(4'b0011, 3'd2, 1'b1, 1'b1);
        run_stream(16'b111111, 16'b011111, 6);
        step(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid;
        do_cfg(4'b0101, 3'd3, 1'b1, 1'b1);
        run_stream(16'b101, 16'b001, 3);
        @(negedge clk);
        x_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (z_q !== 1'b0 || match_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got z_q=%b cnt=%0d expected 0 0", z_q, match_cnt);
        end
        #1 rst = 1'b0;
        exp_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run_stream(16'b1011, 16'b0001, 4);
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_short();
        test_valid_gaps();
        test_len_bounds();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
